lsu_byte_seq: RTL and testbench

Load/store sequencer for the MEM stage of the pipelined reduced RISC-V core. It is the initiator side of the byte-wide data memory port. The memory reads combinationally, writes synchronously, and moves one byte per cycle on bits [7:0]. This block turns each pipeline load or store of byte, halfword or word size into 1, 2 or 4 sequential byte transactions. It holds the pipeline with `busy` and returns a sign- or zero-extended 32-bit load result.

---
 rtl/lsu_byte_seq.sv | 147 ++++++++++++++
 tb/tb_lsu_byte_seq.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/lsu_byte_seq.sv
// ============================================================================
// lsu_byte_seq : MEM-stage load/store sequencer over a byte-wide memory port
// Rev 1.0
// ============================================================================
`default_nettype none

module lsu_byte_seq #(
  parameter int EXT_WIDTH  = 32,
  parameter int DATA_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  input  logic                 req_we,
  input  logic [1:0]           req_size,
  input  logic                 req_unsigned,
  input  logic [EXT_WIDTH-1:0] req_addr,
  input  logic [EXT_WIDTH-1:0] req_wdata,
  output logic                 busy,
  output logic                 rsp_valid,
  output logic [EXT_WIDTH-1:0] rsp_rdata,
  output logic [EXT_WIDTH-1:0] mem_A,
  output logic [EXT_WIDTH-1:0] mem_WD,
  output logic                 mem_WE,
  input  logic [EXT_WIDTH-1:0] mem_RD
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  logic [1:0]           state_q, state_d;
  logic                 we_q, we_d;
  logic [1:0]           size_q, size_d;
  logic                 uns_q, uns_d;
  logic [EXT_WIDTH-1:0] addr_q, addr_d;
  logic [EXT_WIDTH-1:0] wdata_q, wdata_d;
  logic [EXT_WIDTH-1:0] buf_q, buf_d;
  logic [1:0]           idx_q, idx_d;
  logic [1:0]           last_q, last_d;

  logic [DATA_WIDTH-1:0] wr_byte;
  logic                  sign_b, sign_h;
  logic                  unused_rd;

  assign unused_rd = ^mem_RD[EXT_WIDTH-1:DATA_WIDTH];

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      buf_q   <= '0;
      idx_q   <= 2'd0;
      last_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      buf_q   <= buf_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (req_valid) state_d = S_ACCESS;
      S_ACCESS: if (idx_q == last_q) state_d = S_RESP;
      S_RESP:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // last_q holds n-1; reserved size 2'b11 is handled as a word
  always_comb begin
    we_d    = we_q;
    size_d  = size_q;
    uns_d   = uns_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    buf_d   = buf_q;
    idx_d   = idx_q;
    last_d  = last_q;
    if (state_q == S_IDLE && req_valid) begin
      we_d    = req_we;
      size_d  = req_size;
      uns_d   = req_unsigned;
      addr_d  = req_addr;
      wdata_d = req_wdata;
      buf_d   = '0;
      idx_d   = 2'd0;
      case (req_size)
        2'b00:   last_d = 2'd0;
        2'b01:   last_d = 2'd1;
        default: last_d = 2'd3;
      endcase
    end else if (state_q == S_ACCESS) begin
      idx_d = idx_q + 2'd1;
      if (!we_q) buf_d[{idx_q, 3'b000} +: DATA_WIDTH] = mem_RD[DATA_WIDTH-1:0];
    end
  end

  assign wr_byte = wdata_q[{idx_q, 3'b000} +: DATA_WIDTH];
  assign sign_b  = buf_q[DATA_WIDTH-1] & ~uns_q;
  assign sign_h  = buf_q[2*DATA_WIDTH-1] & ~uns_q;

  always_comb begin
    busy      = 1'b0;
    rsp_valid = 1'b0;
    rsp_rdata = '0;
    mem_A     = '0;
    mem_WD    = '0;
    mem_WE    = 1'b0;
    unique case (state_q)
      S_IDLE: busy = req_valid & rst_n;
      S_ACCESS: begin
        busy   = 1'b1;
        mem_A  = addr_q + EXT_WIDTH'(idx_q);
        mem_WE = we_q;
        if (we_q) mem_WD = {{(EXT_WIDTH-DATA_WIDTH){1'b0}}, wr_byte};
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (!we_q) begin
          case (size_q)
            2'b00:   rsp_rdata = {{(EXT_WIDTH-DATA_WIDTH){sign_b}}, buf_q[DATA_WIDTH-1:0]};
            2'b01:   rsp_rdata = {{(EXT_WIDTH-2*DATA_WIDTH){sign_h}}, buf_q[2*DATA_WIDTH-1:0]};
            default: rsp_rdata = buf_q;
          endcase
        end
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_lsu_byte_seq.sv
// ============================================================================
// tb_lsu_byte_seq : directed self-checking bench for lsu_byte_seq
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_lsu_byte_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        busy, rsp_valid, mem_WE;
  logic [31:0] rsp_rdata, mem_A, mem_WD, mem_RD;

  logic [7:0]  mem [0:1023];
  int          n_checks = 0;
  int          n_pass   = 0;

  always #5 clk = ~clk;

  lsu_byte_seq #(.EXT_WIDTH(32), .DATA_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .busy(busy), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .mem_A(mem_A), .mem_WD(mem_WD), .mem_WE(mem_WE), .mem_RD(mem_RD)
  );

  // Byte memory aliased on the low 10 address bits; reads are combinational
  assign mem_RD = {24'h0, mem[mem_A[9:0]]};
  always @(posedge clk) if (mem_WE) mem[mem_A[9:0]] <= mem_WD[7:0];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp, input logic keep);
    int n;
    logic [31:0] a;
    n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    #1;
    chk("busy_accept", {31'h0, busy}, 32'h1);
    chk("rsp_accept", {31'h0, rsp_valid}, 32'h0);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      a = addr + 32'(k);
      chk("mem_A", mem_A, a);
      chk("mem_WE", {31'h0, mem_WE}, {31'h0, we});
      if (we) chk("mem_WD", mem_WD, (wdata >> (8 * k)) & 32'hFF);
      chk("busy_access", {31'h0, busy}, 32'h1);
      chk("rsp_access", {31'h0, rsp_valid}, 32'h0);
    end
    @(negedge clk);
    chk("rsp_valid", {31'h0, rsp_valid}, 32'h1);
    chk("rsp_rdata", rsp_rdata, exp);
    chk("busy_resp", {31'h0, busy}, 32'h0);
    chk("we_resp", {31'h0, mem_WE}, 32'h0);
    if (!keep) begin
      @(negedge clk);
      req_valid = 1'b0;
      #1;
      chk("busy_idle", {31'h0, busy}, 32'h0);
      chk("rsp_idle", {31'h0, rsp_valid}, 32'h0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;

    // Reset state, with a request present
    @(negedge clk);
    req_valid = 1'b1;
    #1;
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_rsp", {31'h0, rsp_valid}, 32'h0);
    chk("rst_we", {31'h0, mem_WE}, 32'h0);
    chk("rst_A", mem_A, 32'h0);
    chk("rst_rdata", rsp_rdata, 32'h0);
    @(negedge clk);
    req_valid = 1'b0;
    rst_n = 1'b1;

    do_req(1'b1, 2'b10, 1'b0, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0, 1'b0);
    do_req(1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 1'b0);
    do_req(1'b0, 2'b00, 1'b0, 32'h0000_0103, 32'h0, 32'hFFFF_FFDE, 1'b0);
    do_req(1'b0, 2'b00, 1'b1, 32'h0000_0103, 32'h0, 32'h0000_00DE, 1'b0);
    do_req(1'b0, 2'b01, 1'b0, 32'h0000_0102, 32'h0, 32'hFFFF_DEAD, 1'b0);
    do_req(1'b0, 2'b01, 1'b1, 32'h0000_0102, 32'h0, 32'h0000_DEAD, 1'b0);
    // Reserved size behaves as a word; unsigned flag ignored for words
    do_req(1'b0, 2'b11, 1'b1, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 1'b0);

    // Wrapping unaligned halfword store
    do_req(1'b1, 2'b01, 1'b0, 32'hFFFF_FFFF, 32'h0000_1234, 32'h0, 1'b0);
    chk("wrap_hi", {24'h0, mem[10'h3FF]}, 32'h34);
    chk("wrap_lo", {24'h0, mem[10'h000]}, 32'h12);
    do_req(1'b0, 2'b01, 1'b1, 32'hFFFF_FFFF, 32'h0, 32'h0000_1234, 1'b0);

    // Reset during the third byte of a word store
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 32'h0000_0200; req_wdata = 32'h1122_3344;
    repeat (3) @(negedge clk);
    chk("mid_A", mem_A, 32'h0000_0202);
    rst_n = 1'b0;
    #1;
    chk("mid_busy", {31'h0, busy}, 32'h0);
    chk("mid_we", {31'h0, mem_WE}, 32'h0);
    chk("mid_A0", mem_A, 32'h0);
    chk("mid_WD0", mem_WD, 32'h0);
    chk("mid_rsp", {31'h0, rsp_valid}, 32'h0);
    @(negedge clk);
    req_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("mid_m200", {24'h0, mem[10'h200]}, 32'h44);
    chk("mid_m201", {24'h0, mem[10'h201]}, 32'h33);
    chk("mid_m202", {24'h0, mem[10'h202]}, 32'h00);
    chk("mid_m203", {24'h0, mem[10'h203]}, 32'h00);
    do_req(1'b0, 2'b00, 1'b1, 32'h0000_0200, 32'h0, 32'h0000_0044, 1'b0);

    // Held request through RESP, then a back-to-back byte load
    do_req(1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 1'b1);
    do_req(1'b0, 2'b00, 1'b0, 32'h0000_0100, 32'h0, 32'hFFFF_FFEF, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
